// File: rtl/ff_pipeline.sv
// ff_pipeline: DEPTH-stage valid/ready register pipeline with bubble collapsing.
// Each stage holds one N-bit word plus a valid bit; the last stage drives the
// output. An empty stage, or one whose item is leaving this cycle, can load
// from the stage before it. A stall therefore packs items towards the output
// instead of freezing the bubbles between them.
//
// Handshake: a transfer happens on an interface at a rising clock edge when
// its valid and ready are both 1. in_ready depends combinationally on
// out_ready through the chain of stage-loadable terms. While out_valid=1 and
// out_ready=0, out_valid and out_data hold. reset and flush both force
// in_ready and out_valid low, so no transfer takes place in that cycle.
module ff_pipeline #(
  parameter int N     = 1,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [CW-1:0] count
);

  logic [N-1:0]     data_q [DEPTH];
  logic [N-1:0]     src_d  [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] src_v;
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] load;
  logic [DEPTH:0]   ok;
  logic             halt;

  // reset and flush both discard every held item and block transfers
  assign halt = reset | flush;

  // Loadable chain, walked from the output back: a stage can accept data
  // when it is empty or when its own item moves on this cycle
  always_comb begin
    logic down;
    ok        = '0;
    down      = out_ready;
    ok[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      down  = ~v_q[k] | down;
      ok[k] = down;
    end
  end

  // Source of each stage: the input port for stage 0, otherwise the stage before it
  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    for (int k = 0; k < DEPTH; k++) begin
      src_d[k] = '0;
    end
    src_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = v_q[k-1];
      src_d[k] = data_q[k-1];
    end
  end

  // Per-stage item departures and loads for this cycle
  always_comb begin
    move = '0;
    load = '0;
    for (int k = 0; k < DEPTH; k++) begin
      move[k] = v_q[k] & ok[k+1];
      load[k] = src_v[k] & ok[k] & ~halt;
    end
  end

  // Valid bits: cleared by reset/flush, set on load, cleared when the item leaves
  always_ff @(posedge clock) begin
    if (halt) begin
      v_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load[k]) begin
          v_q[k] <= 1'b1;
        end else if (move[k]) begin
          v_q[k] <= 1'b0;
        end
      end
    end
  end

  // Data registers: no reset, written only when their stage accepts an item
  always_ff @(posedge clock) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (load[k]) begin
        data_q[k] <= src_d[k];
      end
    end
  end

  // Occupancy: number of set valid bits
  always_comb begin
    count = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count = count + CW'(v_q[k]);
    end
  end

  assign in_ready  = ok[0] & ~halt;
  assign out_valid = v_q[DEPTH-1] & ~halt;
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_ff_pipeline.sv
// tb_ff_pipeline: directed scenarios followed by random traffic for
// ff_pipeline (N=8, DEPTH=3). The reference keeps in-flight items as
// (data, position) pairs and advances each item whenever the slot ahead of it
// is free; an acceptance-order queue supplies the expected output data.
module tb_ff_pipeline;

  localparam int N     = 8;
  localparam int DEPTH = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [CW-1:0] count;

  int vectors     = 0;
  int miscompares = 0;

  // Values seen on the DUT in the most recent cycle
  logic          s_in_ready;
  logic          s_out_valid;
  logic [N-1:0]  s_out_data;
  logic [CW-1:0] s_count;

  typedef struct {
    logic [N-1:0] data;
    int           pos;
  } item_t;

  item_t        model_q[$];
  logic [N-1:0] exp_q[$];
  int           npos[DEPTH+1];

  ff_pipeline #(.N(N), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  // Clock
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: an item leaves from the last slot when downstream is ready;
  // every other item steps forward one slot if that slot ends up free.
  task automatic model_eval(input logic ordy, output logic ir, output logic ov,
                            output int start);
    int lim;
    ov    = (model_q.size() > 0) && (model_q[0].pos == DEPTH - 1);
    start = (ov && ordy) ? 1 : 0;
    lim   = DEPTH - 1;
    for (int i = start; i < model_q.size(); i++) begin
      npos[i] = (model_q[i].pos < lim) ? model_q[i].pos + 1 : model_q[i].pos;
      lim     = npos[i] - 1;
    end
    ir = (lim >= 0);
  endtask

  // One clock cycle: drive inputs, compare against the reference, clock, update reference
  task automatic cycle(input logic rst, input logic fl, input logic iv,
                       input logic [N-1:0] d, input logic ordy, input bit chk);
    logic  ir, ov, ir_g, ov_g, halt;
    int    start;
    item_t nq[$];
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    model_eval(ordy, ir, ov, start);
    halt = rst | fl;
    ir_g = ir & ~halt;
    ov_g = ov & ~halt;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_out_data  = out_data;
    s_count     = count;
    if (chk) begin
      check("in_ready", in_ready, ir_g);
      check("out_valid", out_valid, ov_g);
      check("count", count, model_q.size());
      if (ov_g) check("out_data", out_data, exp_q[0]);
    end
    @(posedge clock);
    if (halt) begin
      model_q.delete();
      exp_q.delete();
    end else begin
      if (ov_g && ordy) void'(exp_q.pop_front());
      for (int i = start; i < model_q.size(); i++) begin
        nq.push_back('{data: model_q[i].data, pos: npos[i]});
      end
      if (iv && ir_g) begin
        nq.push_back('{data: d, pos: 0});
        exp_q.push_back(d);
      end
      model_q = nq;
    end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset: first cycle state is unknown until the edge, then check
    cycle(1, 0, 0, 8'h00, 0, 0);
    cycle(1, 0, 1, 8'h77, 1, 1);
    check("reset_count", s_count, 0);
    check("reset_out_valid", s_out_valid, 0);
    check("reset_in_ready", s_in_ready, 0);

    // Streaming 1,2,3,... with out_ready=1
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 1, 8'(i), 1, 1);
      if (i == 1) check("first_in_ready", s_in_ready, 1);
      check("stream_out_valid", s_out_valid, (i >= 4) ? 1 : 0);
      if (i >= 4) begin
        check("stream_out_data", s_out_data, i - 3);
        check("stream_count", s_count, 3);
      end
    end
    repeat (4) cycle(0, 0, 0, 8'h00, 1, 1);

    // Fill and stall
    for (int j = 0; j < 4; j++) begin
      cycle(0, 0, 1, 8'(8'hA0 + j), 0, 1);
    end
    check("stall_in_ready", s_in_ready, 0);
    check("stall_count", s_count, 3);
    check("stall_out_data", s_out_data, 8'hA0);
    cycle(0, 0, 1, 8'hA3, 0, 1);
    check("stall_hold_data", s_out_data, 8'hA0);
    check("stall_hold_valid", s_out_valid, 1);
    cycle(0, 0, 1, 8'hA3, 1, 1);
    check("release_in_ready", s_in_ready, 1);
    check("release_out_data", s_out_data, 8'hA0);
    repeat (5) cycle(0, 0, 0, 8'h00, 1, 1);

    // Bubble collapse
    cycle(0, 0, 1, 8'h11, 0, 1);
    cycle(0, 0, 0, 8'h00, 0, 1);
    cycle(0, 0, 0, 8'h00, 0, 1);
    cycle(0, 0, 1, 8'h22, 0, 1);
    cycle(0, 0, 0, 8'h00, 0, 1);
    cycle(0, 0, 0, 8'h00, 0, 1);
    check("bubble_count", s_count, 2);
    check("bubble_in_ready", s_in_ready, 1);
    check("bubble_out_data", s_out_data, 8'h11);
    repeat (5) cycle(0, 0, 0, 8'h00, 1, 1);

    // Full pass-through
    for (int j = 0; j < 3; j++) cycle(0, 0, 1, 8'(8'hB0 + j), 0, 1);
    for (int j = 3; j < 8; j++) begin
      cycle(0, 0, 1, 8'(8'hB0 + j), 1, 1);
      check("pass_in_ready", s_in_ready, 1);
      check("pass_count", s_count, 3);
      check("pass_out_data", s_out_data, 8'hB0 + j - 3);
    end

    // Flush with a full pipe and an offered item
    cycle(0, 1, 1, 8'hEE, 1, 1);
    check("flush_in_ready", s_in_ready, 0);
    check("flush_out_valid", s_out_valid, 0);
    cycle(0, 0, 0, 8'h00, 1, 1);
    check("post_flush_count", s_count, 0);
    check("post_flush_out_valid", s_out_valid, 0);

    // Reset together with flush during streaming
    for (int j = 0; j < 4; j++) cycle(0, 0, 1, 8'(8'hC0 + j), 1, 1);
    cycle(1, 1, 1, 8'hDD, 1, 1);
    check("midreset_in_ready", s_in_ready, 0);
    check("midreset_out_valid", s_out_valid, 0);
    cycle(0, 0, 1, 8'h5A, 1, 1);
    check("after_reset_count", s_count, 0);
    check("after_reset_in_ready", s_in_ready, 1);
    cycle(0, 0, 0, 8'h00, 1, 1);
    check("latency_c1", s_out_valid, 0);
    cycle(0, 0, 0, 8'h00, 1, 1);
    check("latency_c2", s_out_valid, 0);
    cycle(0, 0, 0, 8'h00, 1, 1);
    check("latency_c3_valid", s_out_valid, 1);
    check("latency_c3_data", s_out_data, 8'h5A);

    // Random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) != 0), 8'($urandom),
            ($urandom_range(0, 2) != 0), 1);
    end
    repeat (6) cycle(0, 0, 0, 8'h00, 1, 1);
    check("final_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
